// File: rtl/rggen_trigger_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// rggen_trigger_dispatcher_pkg
//
// Shared types for the trigger dispatcher and its round-robin selector.
//
// Contents:
//   state_e   - dispatcher FSM state (IDLE / ISSUE / WAIT), 2-bit encoded
// -----------------------------------------------------------------------------
package rggen_trigger_dispatcher_pkg;

  // IDLE : choose the next pending channel (if any)
  // ISSUE: command presented to the engine, waiting for i_cmd_ready
  // WAIT : command accepted, waiting for i_done (or timeout expiry)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage : rggen_trigger_dispatcher_pkg

// File: rtl/rggen_round_robin_selector.sv
// -----------------------------------------------------------------------------
// rggen_round_robin_selector
//
// Purely combinational round-robin pick: starting at last_grant_i + 1 and
// wrapping modulo CHANNELS, return the first asserted request bit.
//
// Ports:
//   request_i     [CHANNELS]     request vector
//   last_grant_i  [INDEX_WIDTH]  index granted most recently
//   found_o       [1]            at least one request is asserted
//   index_o       [INDEX_WIDTH]  selected index (0 when found_o is low)
// -----------------------------------------------------------------------------
module rggen_round_robin_selector #(
  parameter  int CHANNELS    = 4,
  localparam int INDEX_WIDTH = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]    request_i,
  input  logic [INDEX_WIDTH-1:0] last_grant_i,
  output logic                   found_o,
  output logic [INDEX_WIDTH-1:0] index_o
);

  // Walk the channels in priority order; the first hit latches found_o and
  // masks every later candidate. The loop bound is static, so this unrolls
  // into a plain priority chain.
  always_comb begin
    int unsigned cand;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch to hold it.
    found_o = 1'b0;
    index_o = '0;
    cand    = 0;
    for (int off = 1; off <= CHANNELS; off++) begin
      cand = (int'(last_grant_i) + off) % CHANNELS;
      if (!found_o && request_i[INDEX_WIDTH'(cand)]) begin
        found_o = 1'b1;
        index_o = INDEX_WIDTH'(cand);
      end
    end
  end

endmodule : rggen_round_robin_selector

// File: rtl/rggen_trigger_dispatcher.sv
// -----------------------------------------------------------------------------
// rggen_trigger_dispatcher
//
// Collects one-shot trigger pulses (one per channel, from write-trigger bit
// fields), latches them as pending, and dispatches them one at a time to a
// single shared engine over a valid/ready command handshake. After each
// accepted command it waits for i_done, optionally bounded by a timeout.
//
// Ports:
//   i_clk             clock
//   i_rst_n           asynchronous active-low reset
//   i_trigger         [CHANNELS]    single-cycle trigger pulses
//   o_cmd_valid       command request to the engine
//   i_cmd_ready       engine accepts command
//   o_cmd_index       [INDEX_WIDTH] channel being dispatched
//   i_done            engine completion pulse
//   o_busy            FSM not in IDLE
//   o_pending         [CHANNELS]    latched, not-yet-dispatched triggers
//   o_overflow        [CHANNELS]    sticky: trigger while already pending
//   i_overflow_clear  [CHANNELS]    per-channel clear for o_overflow
//   o_timeout         sticky timeout flag
//   i_timeout_clear   clear for o_timeout
// -----------------------------------------------------------------------------
module rggen_trigger_dispatcher
  import rggen_trigger_dispatcher_pkg::*;
#(
  parameter  int CHANNELS      = 4,
  parameter  int TIMEOUT       = 0,
  parameter  int TIMEOUT_WIDTH = 16,
  localparam int INDEX_WIDTH   = $clog2(CHANNELS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [CHANNELS-1:0]    i_trigger,
  output logic                   o_cmd_valid,
  input  logic                   i_cmd_ready,
  output logic [INDEX_WIDTH-1:0] o_cmd_index,
  input  logic                   i_done,
  output logic                   o_busy,
  output logic [CHANNELS-1:0]    o_pending,
  output logic [CHANNELS-1:0]    o_overflow,
  input  logic [CHANNELS-1:0]    i_overflow_clear,
  output logic                   o_timeout,
  input  logic                   i_timeout_clear
);

  // Timeout is compiled out entirely when TIMEOUT == 0.
  localparam bit                     TO_EN   = (TIMEOUT > 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  // Last-grant starts at the top channel so channel 0 wins first after reset.
  localparam logic [INDEX_WIDTH-1:0]   LAST_GRANT_INIT = INDEX_WIDTH'(CHANNELS - 1);

  state_e                   state_q, state_d;
  logic [CHANNELS-1:0]      pending_q, pending_d;
  logic [CHANNELS-1:0]      overflow_q, overflow_d;
  logic [CHANNELS-1:0]      grant_clear;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic [INDEX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [INDEX_WIDTH-1:0]   sel_index;
  logic                     sel_found;
  logic                     handshake;
  logic                     timeout_expire;
  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  logic                     timeout_q, timeout_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rggen_round_robin_selector #(
    .CHANNELS (CHANNELS)
  ) u_selector (
    .request_i    (pending_q),
    .last_grant_i (last_grant_q),
    .found_o      (sel_found),
    .index_o      (sel_index)
  );

  // ---------------------------------------------------------------------------
  // Handshake / pending / overflow
  // ---------------------------------------------------------------------------
  assign handshake   = (state_q == ST_ISSUE) && i_cmd_ready;
  assign grant_clear = handshake ? (CHANNELS'(1) << index_q) : '0;

  // OR-ing the trigger in after the clear makes a trigger that lands in the
  // handshake cycle of its own channel re-arm it (set wins).
  assign pending_d = (pending_q & ~grant_clear) | i_trigger;

  // A retrigger in the handshake cycle opens a new pending period, so it is
  // not an overflow. Set takes priority over the W1C clear.
  assign overflow_d = (overflow_q & ~i_overflow_clear)
                    | (i_trigger & pending_q & ~grant_clear);

  // ---------------------------------------------------------------------------
  // Timeout: counter runs only in WAIT; i_done in the expiry cycle wins.
  // ---------------------------------------------------------------------------
  assign timeout_expire = TO_EN && (state_q == ST_WAIT) && !i_done
                       && (count_q == TO_LAST);

  always_comb begin
    count_d = count_q;
    if (handshake) begin
      count_d = '0;
    end else if (TO_EN && (state_q == ST_WAIT)) begin
      count_d = count_q + TIMEOUT_WIDTH'(1);
    end
  end

  assign timeout_d = timeout_expire | (timeout_q & ~i_timeout_clear);

  // ---------------------------------------------------------------------------
  // Index / last-grant tracking
  // ---------------------------------------------------------------------------
  // The index is latched only when leaving IDLE, so it stays frozen under any
  // amount of backpressure in ISSUE regardless of new triggers.
  always_comb begin
    index_d = index_q;
    if ((state_q == ST_IDLE) && sel_found) begin
      index_d = sel_index;
    end
  end

  assign last_grant_d = handshake ? index_q : last_grant_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples its inputs from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // i_done is deliberately ignored here: no command is outstanding yet.
        if (i_cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_done || timeout_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_cmd_valid = (state_q == ST_ISSUE);
    o_busy      = (state_q != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: all of these are control/status flops, not storage arrays, so each
  // one gets an explicit async reset value; an abandoned command must leave
  // nothing pending or flagged behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q    <= '0;
      overflow_q   <= '0;
      index_q      <= '0;
      last_grant_q <= LAST_GRANT_INIT;
      count_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      index_q      <= index_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_cmd_index = index_q;
  assign o_pending   = pending_q;
  assign o_overflow  = overflow_q;
  assign o_timeout   = timeout_q;

endmodule : rggen_trigger_dispatcher

// File: tb/tb_rggen_trigger_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_rggen_trigger_dispatcher
//
// Self-checking bench for rggen_trigger_dispatcher (CHANNELS=4, TIMEOUT=4).
// Inputs change 1 ns after a rising edge; outputs are checked right after
// that, i.e. they reflect the state produced by the edge just taken.
// Dispatched commands are checked against an expected-index queue on the
// falling edge of every handshake cycle.
// -----------------------------------------------------------------------------
module tb_rggen_trigger_dispatcher;

  localparam int CH = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [CH-1:0] i_trigger;
  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic [1:0]    o_cmd_index;
  logic          i_done;
  logic          o_busy;
  logic [CH-1:0] o_pending;
  logic [CH-1:0] o_overflow;
  logic [CH-1:0] i_overflow_clear;
  logic          o_timeout;
  logic          i_timeout_clear;

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned exp_q[$];

  always #5 i_clk = ~i_clk;

  rggen_trigger_dispatcher #(
    .CHANNELS      (CH),
    .TIMEOUT       (4),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_trigger        (i_trigger),
    .o_cmd_valid      (o_cmd_valid),
    .i_cmd_ready      (i_cmd_ready),
    .o_cmd_index      (o_cmd_index),
    .i_done           (i_done),
    .o_busy           (o_busy),
    .o_pending        (o_pending),
    .o_overflow       (o_overflow),
    .i_overflow_clear (i_overflow_clear),
    .o_timeout        (o_timeout),
    .i_timeout_clear  (i_timeout_clear)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Run until idle with nothing pending; an expired budget is a failure.
  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (!o_busy && o_pending == '0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Scoreboard: every accepted command must match the next expected index.
  always @(negedge i_clk) begin
    if (i_rst_n && o_cmd_valid && i_cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_extra: unexpected command, index %0d", o_cmd_index);
      end else begin
        check("sb_index", 32'(o_cmd_index), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [CH-1:0] trig;
    logic          rdy;
    logic          done;
    logic [CH-1:0] oclr;
    logic [CH-1:0] exp_pend;
    logic [CH-1:0] exp_ovf;
    logic          exp_valid;
    logic          exp_busy;
    logic [1:0]    exp_idx;   // compared only while exp_valid
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Test 1 (rows 0-6): single trigger on ch2, done 3 cycles after handshake.
    tbl[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2};
    tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    // Test 3 (rows 7-16): overflow on ch1, W1C clear, clear vs. set collision.
    tbl[7]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 2'd0};
    tbl[15] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};

    i_rst_n          = 1'b0;
    i_trigger        = '0;
    i_cmd_ready      = 1'b0;
    i_done           = 1'b0;
    i_overflow_clear = '0;
    i_timeout_clear  = 1'b0;
    #23;
    i_rst_n = 1'b1;

    // ---- Reset state ----
    check("rst_valid",    32'(o_cmd_valid), 32'd0);
    check("rst_index",    32'(o_cmd_index), 32'd0);
    check("rst_busy",     32'(o_busy),      32'd0);
    check("rst_pending",  32'(o_pending),   32'd0);
    check("rst_overflow", 32'(o_overflow),  32'd0);
    check("rst_timeout",  32'(o_timeout),   32'd0);

    // ---- Test 2: 1011 -> 0,1,3; retrigger 0011 in ch3's grant cycle -> 0,1 ----
    begin
      bit retrig;
      retrig = 1'b0;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      exp_q.push_back(0); exp_q.push_back(1);
      i_cmd_ready = 1'b1;
      i_done      = 1'b1;
      i_trigger   = 4'b1011;
      tick();
      i_trigger   = '0;
      for (int c = 0; c < 60; c++) begin
        if (!retrig && o_cmd_valid && o_cmd_index == 2'd3) begin
          i_trigger = 4'b0011;
          retrig    = 1'b1;
        end
        tick();
        i_trigger = '0;
        if (retrig && !o_busy && o_pending == '0) break;
      end
      check("t2_retrig_seen", 32'(retrig),     32'd1);
      check("t2_drained",     32'(exp_q.size()), 32'd0);
      check("t2_overflow",    32'(o_overflow), 32'd0);
      check("t2_busy",        32'(o_busy),     32'd0);
    end
    i_done      = 1'b0;
    i_cmd_ready = 1'b0;

    // ---- Tests 1 and 3: table-driven ----
    exp_q.push_back(2);
    exp_q.push_back(1);
    exp_q.push_back(1);
    for (int i = 0; i < 17; i++) begin
      i_trigger        = tbl[i].trig;
      i_cmd_ready      = tbl[i].rdy;
      i_done           = tbl[i].done;
      i_overflow_clear = tbl[i].oclr;
      tick();
      check($sformatf("tbl[%0d].pending", i),  32'(o_pending),   32'(tbl[i].exp_pend));
      check($sformatf("tbl[%0d].overflow", i), 32'(o_overflow),  32'(tbl[i].exp_ovf));
      check($sformatf("tbl[%0d].valid", i),    32'(o_cmd_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl[%0d].busy", i),     32'(o_busy),      32'(tbl[i].exp_busy));
      check($sformatf("tbl[%0d].timeout", i),  32'(o_timeout),   32'd0);
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl[%0d].index", i), 32'(o_cmd_index), 32'(tbl[i].exp_idx));
      end
    end
    i_trigger        = '0;
    i_cmd_ready      = 1'b0;
    i_done           = 1'b0;
    i_overflow_clear = '0;
    check("t13_drained", 32'(exp_q.size()), 32'd0);

    // ---- Test 4: backpressure holds index; same-channel retrigger at grant ----
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0);
    i_trigger = 4'b0001;
    tick();
    i_trigger = '0;
    check("t4_pending", 32'(o_pending), 32'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) i_trigger = 4'b0100;
      tick();
      i_trigger = '0;
      check($sformatf("t4_valid[%0d]", k), 32'(o_cmd_valid), 32'd1);
      check($sformatf("t4_index[%0d]", k), 32'(o_cmd_index), 32'd0);
    end
    i_cmd_ready = 1'b1;
    i_trigger   = 4'b0001;
    tick();
    i_trigger   = '0;
    check("t4_rearm_pending",  32'(o_pending),   32'b0101);
    check("t4_rearm_overflow", 32'(o_overflow),  32'd0);
    check("t4_wait_valid",     32'(o_cmd_valid), 32'd0);
    i_done = 1'b1;
    wait_idle("t4_idle", 40);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    i_done = 1'b0;

    // ---- Test 5: timeout after 4 WAIT cycles, then done-in-expiry-cycle ----
    exp_q.push_back(1); exp_q.push_back(0);
    i_cmd_ready = 1'b1;
    i_trigger   = 4'b0011;
    tick();
    i_trigger   = '0;
    tick();
    check("t5_issue_index", 32'(o_cmd_index), 32'd1);
    tick();                       // handshake -> WAIT
    tick(); tick(); tick();       // three more WAIT cycles
    check("t5_pre_busy",    32'(o_busy),    32'd1);
    check("t5_pre_timeout", 32'(o_timeout), 32'd0);
    tick();                       // fourth WAIT cycle expires
    check("t5_timeout_set", 32'(o_timeout), 32'd1);
    check("t5_abort_busy",  32'(o_busy),    32'd0);
    tick();
    check("t5_next_valid",  32'(o_cmd_valid), 32'd1);
    check("t5_next_index",  32'(o_cmd_index), 32'd0);
    tick();                       // handshake for ch0 -> WAIT
    i_timeout_clear = 1'b1;
    tick();
    i_timeout_clear = 1'b0;
    check("t5_timeout_clr", 32'(o_timeout), 32'd0);
    tick(); tick();               // now in the expiry cycle
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    check("t5_done_wins_timeout", 32'(o_timeout), 32'd0);
    check("t5_done_wins_busy",    32'(o_busy),    32'd0);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    i_cmd_ready = 1'b0;

    // ---- Test 6: async reset mid-WAIT ----
    exp_q.push_back(0);
    i_trigger = 4'b0001;
    tick();
    tick();                       // second trigger while pending -> overflow
    i_trigger   = '0;
    i_cmd_ready = 1'b1;
    tick();                       // handshake -> WAIT
    i_cmd_ready = 1'b0;
    i_trigger   = 4'b1010;
    tick();
    i_trigger   = '0;
    check("t6_pre_pending",  32'(o_pending),  32'b1010);
    check("t6_pre_overflow", 32'(o_overflow), 32'b0001);
    check("t6_pre_busy",     32'(o_busy),     32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_pending",  32'(o_pending),   32'd0);
    check("t6_rst_overflow", 32'(o_overflow),  32'd0);
    check("t6_rst_busy",     32'(o_busy),      32'd0);
    check("t6_rst_valid",    32'(o_cmd_valid), 32'd0);
    check("t6_rst_index",    32'(o_cmd_index), 32'd0);
    check("t6_rst_timeout",  32'(o_timeout),   32'd0);
    tick();
    #2;
    i_rst_n = 1'b1;
    exp_q.push_back(0); exp_q.push_back(3);
    i_cmd_ready = 1'b1;
    i_done      = 1'b1;
    i_trigger   = 4'b1001;
    tick();
    i_trigger   = '0;
    tick();
    check("t6_first_grant", 32'(o_cmd_index), 32'd0);
    wait_idle("t6_idle", 40);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_rggen_trigger_dispatcher
